// File: rtl/regop_pkg.sv
// Shared encodings for the register-operation sequencer: bank FunSel codes and FSM states.
package regop_pkg;

   localparam logic [1:0] FS_DEC  = 2'b00;
   localparam logic [1:0] FS_INC  = 2'b01;
   localparam logic [1:0] FS_LOAD = 2'b10;
   localparam logic [1:0] FS_CLR  = 2'b11;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t SNAP  = 2'd1;
   localparam state_t ISSUE = 2'd2;
   localparam state_t CHECK = 2'd3;

endpackage

// File: rtl/regop_expect.sv
// Combinational model of what the target register should hold after count+1 issue edges.
module regop_expect
   import regop_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic [1:0]       funsel,
   input  logic [WIDTH-1:0] base,
   input  logic [WIDTH-1:0] data,
   input  logic [3:0]       count,
   output logic [WIDTH-1:0] expected_c
);

   logic [WIDTH-1:0] step;

   // Number of issue edges; arithmetic wraps modulo 2^WIDTH.
   assign step = WIDTH'(count) + WIDTH'(1);

   always_comb begin
      expected_c = '0;
      case (funsel)
         FS_DEC:  expected_c = base - step;
         FS_INC:  expected_c = base + step;
         FS_LOAD: expected_c = data;
         default: expected_c = '0;
      endcase
   end

endmodule

// File: rtl/reg_op_sequencer.sv
// Issues one register-bank micro-op for count+1 cycles, then reads back and checks the result.
module reg_op_sequencer
   import regop_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NREG  = 4
) (
   input  logic                    Clock,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [$clog2(NREG)-1:0] cmd_sel,
   input  logic [1:0]              cmd_funsel,
   input  logic [WIDTH-1:0]        cmd_data,
   input  logic [3:0]              cmd_count,
   output logic [NREG-1:0]         reg_E,
   output logic [1:0]              reg_FunSel,
   output logic [WIDTH-1:0]        reg_I,
   input  logic [NREG*WIDTH-1:0]   reg_Q,
   output logic                    done,
   output logic                    mismatch,
   output logic [WIDTH-1:0]        result
);

   localparam int unsigned SELW = $clog2(NREG);

   state_t           state_q, state_d;
   logic [SELW-1:0]  sel_q, sel_d;
   logic [3:0]       count_q, count_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] base_q, base_d;
   logic [1:0]       funsel_d;
   logic [WIDTH-1:0] data_d;
   logic [NREG-1:0]  en_d;
   logic             ready_d, done_d, mismatch_d;
   logic [WIDTH-1:0] result_d;
   logic [WIDTH-1:0] q_sel;
   logic [WIDTH-1:0] expected_c;

   assign q_sel = reg_Q[32'(sel_q) * WIDTH +: WIDTH];

   regop_expect #(.WIDTH(WIDTH)) u_expect (
      .funsel     (reg_FunSel),
      .base       (base_q),
      .data       (reg_I),
      .count      (count_q),
      .expected_c (expected_c)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      count_d    = count_q;
      cnt_d      = cnt_q;
      base_d     = base_q;
      funsel_d   = reg_FunSel;
      data_d     = reg_I;
      done_d     = 1'b0;
      mismatch_d = mismatch;
      result_d   = result;
      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               sel_d    = cmd_sel;
               funsel_d = cmd_funsel;
               data_d   = cmd_data;
               count_d  = cmd_count;
               cnt_d    = cmd_count;
               state_d  = SNAP;
            end
         end
         SNAP: begin
            base_d  = q_sel;
            state_d = ISSUE;
         end
         ISSUE: begin
            if (cnt_q == 4'd0) state_d = CHECK;
            else               cnt_d   = cnt_q - 4'd1;
         end
         CHECK: begin
            result_d   = q_sel;
            mismatch_d = (q_sel != expected_c);
            done_d     = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE);
      en_d    = (state_d == ISSUE) ? (NREG'(1) << sel_d) : '0;
   end

   // Reset drops reg_E immediately and discards any command in flight.
   always_ff @(posedge Clock or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         sel_q      <= '0;
         count_q    <= '0;
         cnt_q      <= '0;
         base_q     <= '0;
         reg_FunSel <= 2'b00;
         reg_I      <= '0;
         reg_E      <= '0;
         cmd_ready  <= 1'b0;
         done       <= 1'b0;
         mismatch   <= 1'b0;
         result     <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         count_q    <= count_d;
         cnt_q      <= cnt_d;
         base_q     <= base_d;
         reg_FunSel <= funsel_d;
         reg_I      <= data_d;
         reg_E      <= en_d;
         cmd_ready  <= ready_d;
         done       <= done_d;
         mismatch   <= mismatch_d;
         result     <= result_d;
      end
   end

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Directed bench: sequencer driving a four-register behavioural bank.
module tb_reg_op_sequencer;

   logic        Clock;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_sel;
   logic [1:0]  cmd_funsel;
   logic [15:0] cmd_data;
   logic [3:0]  cmd_count;
   logic [3:0]  reg_E;
   logic [1:0]  reg_FunSel;
   logic [15:0] reg_I;
   logic [63:0] reg_Q;
   logic        done;
   logic        mismatch;
   logic [15:0] result;

   logic [15:0] bank [4];
   logic [3:0]  stuck;
   logic        pre_en;
   logic [1:0]  pre_idx;
   logic [15:0] pre_val;

   int checks = 0;
   int errors = 0;
   int n;
   int ecyc;

   reg_op_sequencer #(.WIDTH(16), .NREG(4)) dut (
      .Clock      (Clock),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_sel    (cmd_sel),
      .cmd_funsel (cmd_funsel),
      .cmd_data   (cmd_data),
      .cmd_count  (cmd_count),
      .reg_E      (reg_E),
      .reg_FunSel (reg_FunSel),
      .reg_I      (reg_I),
      .reg_Q      (reg_Q),
      .done       (done),
      .mismatch   (mismatch),
      .result     (result)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Bank model: dec/inc/load/clear on enable; stuck registers ignore their enable.
   always @(posedge Clock) begin
      for (int k = 0; k < 4; k++) begin
         if (pre_en && pre_idx == 2'(k)) bank[k] <= pre_val;
         else if (reg_E[k] && !stuck[k]) begin
            case (reg_FunSel)
               2'b00:   bank[k] <= bank[k] - 16'd1;
               2'b01:   bank[k] <= bank[k] + 16'd1;
               2'b10:   bank[k] <= reg_I;
               default: bank[k] <= 16'd0;
            endcase
         end
      end
   end

   assign reg_Q = {bank[3], bank[2], bank[1], bank[0]};

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [1:0] idx, input logic [15:0] val);
      pre_en  = 1'b1;
      pre_idx = idx;
      pre_val = val;
      tick();
      pre_en  = 1'b0;
   endtask

   // Presents a command for one edge (edge A); returns at A+#1.
   task automatic issue(input string tag, input logic [1:0] sel, input logic [1:0] fs,
                        input logic [15:0] data, input logic [3:0] count);
      chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
      cmd_sel    = sel;
      cmd_funsel = fs;
      cmd_data   = data;
      cmd_count  = count;
      cmd_valid  = 1'b1;
      tick();
      cmd_valid  = 1'b0;
   endtask

   // Edges from acceptance to done, and cycles the target enable was observed.
   task automatic wait_done(input logic [3:0] oh, output int lat, output int ec);
      lat = 0;
      ec  = 0;
      while (done !== 1'b1 && lat < 40) begin
         tick();
         lat++;
         if (reg_E === oh) ec++;
      end
   endtask

   initial begin
      rst        = 1'b0;
      cmd_valid  = 1'b0;
      cmd_sel    = '0;
      cmd_funsel = '0;
      cmd_data   = '0;
      cmd_count  = '0;
      stuck      = '0;
      pre_en     = 1'b0;
      pre_idx    = '0;
      pre_val    = '0;
      #2;
      chk("rst_ready",    32'(cmd_ready),  32'd0);
      chk("rst_E",        32'(reg_E),      32'd0);
      chk("rst_funsel",   32'(reg_FunSel), 32'd0);
      chk("rst_I",        32'(reg_I),      32'd0);
      chk("rst_done",     32'(done),       32'd0);
      chk("rst_mismatch", 32'(mismatch),   32'd0);
      chk("rst_result",   32'(result),     32'd0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("rel_ready", 32'(cmd_ready), 32'd1);

      // inc R1 from 5, three issue cycles
      preload(2'd1, 16'h0005);
      issue("t1", 2'd1, 2'b01, 16'h0000, 4'd2);
      chk("t1_snap_E", 32'(reg_E),      32'd0);
      chk("t1_funsel", 32'(reg_FunSel), 32'd1);
      wait_done(4'b0010, n, ecyc);
      chk("t1_lat",      32'(n),         32'd5);
      chk("t1_ecyc",     32'(ecyc),      32'd3);
      chk("t1_result",   32'(result),    32'h0008);
      chk("t1_mismatch", 32'(mismatch),  32'd0);
      chk("t1_ready",    32'(cmd_ready), 32'd1);
      tick();
      chk("t1_done_pulse", 32'(done), 32'd0);

      // dec R0 from 0 wraps to FFFF
      preload(2'd0, 16'h0000);
      issue("t2", 2'd0, 2'b00, 16'h0000, 4'd0);
      wait_done(4'b0001, n, ecyc);
      chk("t2_lat",      32'(n),        32'd3);
      chk("t2_ecyc",     32'(ecyc),     32'd1);
      chk("t2_result",   32'(result),   32'hFFFF);
      chk("t2_mismatch", 32'(mismatch), 32'd0);

      // load R3, repeated four times
      issue("t3", 2'd3, 2'b10, 16'hBEEF, 4'd3);
      chk("t3_I", 32'(reg_I), 32'hBEEF);
      wait_done(4'b1000, n, ecyc);
      chk("t3_lat",      32'(n),        32'd6);
      chk("t3_ecyc",     32'(ecyc),     32'd4);
      chk("t3_result",   32'(result),   32'hBEEF);
      chk("t3_mismatch", 32'(mismatch), 32'd0);

      // R2 stuck: readback differs from expected
      stuck = 4'b0100;
      preload(2'd2, 16'h1234);
      issue("t4", 2'd2, 2'b01, 16'h0000, 4'd0);
      wait_done(4'b0100, n, ecyc);
      chk("t4_lat",      32'(n),        32'd3);
      chk("t4_result",   32'(result),   32'h1234);
      chk("t4_mismatch", 32'(mismatch), 32'd1);
      stuck = 4'b0000;

      // inc past FFFF wraps without mismatch
      preload(2'd2, 16'hFFFF);
      issue("t4b", 2'd2, 2'b01, 16'h0000, 4'd1);
      wait_done(4'b0100, n, ecyc);
      chk("t4b_result",   32'(result),   32'h0001);
      chk("t4b_mismatch", 32'(mismatch), 32'd0);

      // reset during the second issue cycle
      preload(2'd1, 16'h0000);
      issue("t5", 2'd1, 2'b01, 16'h0000, 4'd5);
      tick();
      chk("t5_issue1_E", 32'(reg_E), 32'b0010);
      tick();
      rst = 1'b0;
      #1;
      chk("t5_rst_E",     32'(reg_E),     32'd0);
      chk("t5_rst_done",  32'(done),      32'd0);
      chk("t5_rst_ready", 32'(cmd_ready), 32'd0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("t5_rel_ready", 32'(cmd_ready), 32'd1);
      chk("t5_rel_done",  32'(done),      32'd0);
      chk("t5_rel_E",     32'(reg_E),     32'd0);
      chk("t5_R1",        32'(bank[1]),   32'h0001);

      // back-to-back: clear R0 then inc R0 with valid held
      preload(2'd0, 16'h0077);
      issue("t6a", 2'd0, 2'b11, 16'h0000, 4'd0);
      cmd_valid  = 1'b1;
      cmd_funsel = 2'b01;
      tick();
      chk("t6_issue_E", 32'(reg_E), 32'b0001);
      tick();
      tick();
      chk("t6a_done",   32'(done),      32'd1);
      chk("t6a_result", 32'(result),    32'h0000);
      chk("t6a_ready",  32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
      chk("t6b_accept_done",  32'(done),      32'd0);
      chk("t6b_accept_ready", 32'(cmd_ready), 32'd0);
      tick();
      tick();
      tick();
      chk("t6b_done",     32'(done),     32'd1);
      chk("t6b_result",   32'(result),   32'h0001);
      chk("t6b_mismatch", 32'(mismatch), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_op_sequencer.md
# reg_op_sequencer

Command-driven micro-op issuer for the 16-bit register bank: it accepts a register operation over a valid/ready handshake and drives the enable, FunSel and data inputs of one selected register for a programmable number of cycles. It then reads back that register's Q output and reports the final value. It also flags whether the final value matches the arithmetically expected result. It sits between the control unit and the bank, acting as the driving end of the bank's E/FunSel/I interface and the reader of its Q outputs.

## Interface
- WIDTH, 16, register data width
- NREG, 4, registers in the bank (power of 2)
- Clock  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_sel  in  log2(NREG)  target register index
- cmd_funsel  in  2  operation: 00 dec, 01 inc, 10 load, 11 clear
- cmd_data  in  WIDTH  load value (used only for 10)
- cmd_count  in  4  issue cycles minus 1
- reg_E  out  NREG  one-hot register enables
- reg_FunSel  out  2  FunSel to bank (shared)
- reg_I  out  WIDTH  data to bank (shared)
- reg_Q  in  NREG*WIDTH  packed bank outputs, register k at [k*WIDTH +: WIDTH]
- done  out  1  one-cycle completion pulse
- mismatch  out  1  valid with done: readback ≠ expected
- result  out  WIDTH  readback value, held until next done

## Operation
- FSM states: IDLE, SNAP, ISSUE, CHECK.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch sel, funsel, data and count. Then go to SNAP.
- SNAP: capture reg_Q[sel] into base. Go to ISSUE.
- ISSUE: reg_E[sel]=1, all other reg_E bits 0. Down-counter starts at the latched count and decrements each cycle. Leave for CHECK when the counter is 0, giving exactly count+1 issue cycles.
- CHECK: reg_E=0. Sample reg_Q[sel] into result. Set mismatch=(reg_Q[sel]≠expected) and pulse done. Return to IDLE.
- Expected value, modulo 2^WIDTH:
  - dec: base−(count+1)
  - inc: base+(count+1)
  - load: data
  - clear: 0
- reg_FunSel and reg_I drive the latched funsel and data continuously. reg_E is the only qualifier.
- cmd_* inputs are ignored outside IDLE. Other registers' Q values are ignored.
- Repeated load or clear (count>0) is legal. The expected value is unchanged.

## Timing
- Take the acceptance edge as edge A.
- Edge A+1: enter ISSUE.
- reg_E high during cycles A+1 … A+1+count, i.e. count+1 bank edges.
- Edge A+2+count: enter CHECK.
- Edge A+3+count: done=1, result and mismatch updated, cmd_ready=1.
- A new command may be accepted in the done cycle (back-to-back, no bubble).
- Reset values:
  - state IDLE, cmd_ready=0 while rst low and 1 after release
  - reg_E=0, reg_FunSel=00, reg_I=0
  - done=0, mismatch=0, result=0
- Reset mid-operation: reg_E drops to 0 asynchronously and the command is discarded with no done. Bank edges already issued stand.
- Wrap-around: dec past 0 and inc past 0xFFFF wrap silently. Neither case is a mismatch.

## Structure
- Package regop_pkg holds the FunSel encodings (FS_DEC, FS_INC, FS_LOAD, FS_CLR) and the state enum (IDLE, SNAP, ISSUE, CHECK).
- Sub-module regop_expect computes the combinational expected value from funsel, base, data and count, parameterised by WIDTH.
- The bench instantiates four bank registers (WIDTH=16, FunSel semantics above) driven by reg_E/reg_FunSel/reg_I, with Q values packed into reg_Q.

## Test plan
- Reset release, R1 preloaded 0x0005; cmd inc, sel=1, count=2 → reg_E=0010 for 3 cycles, done at A+5, result 0x0008, mismatch 0.
- R0=0x0000; cmd dec, sel=0, count=0 → one issue cycle, result 0xFFFF, mismatch 0.
- cmd load, sel=3, data 0xBEEF, count=3 → reg_E=1000 for 4 cycles, reg_I=0xBEEF, result 0xBEEF, mismatch 0.
- Bank model holds R2 stuck at 0x1234; cmd inc, sel=2, count=0 → result 0x1234, mismatch 1.
- R1=0x0000; cmd inc, sel=1, count=5; rst low during the 2nd ISSUE cycle → reg_E=0 immediately, no done, cmd_ready=1 after release, R1 incremented exactly once.
- cmd_valid held with two queued commands (clear sel=0, then inc sel=0 count=0) → second accepted in the first's done cycle, second done 3 cycles later, result 0x0001.
